goomba_scheduler: RTL and testbench
===================================

Name: goomba_scheduler

Overview:
- Sequences a bank of N Goomba enemy instances.
- Releases each Goomba's initial_show as the camera scrolls toward its fixed spawn X.
- Shares one external collision checker among live Goombas using a round-robin request/response handshake.
- Converts checker results into per-Goomba toggle impulses: collapsion toggles turn the Goomba around, press toggles squash it. Sits between the camera/scroll logic, the collision checker and the Goomba instances.

Parameters:
- N_SLOTS, 4, number of Goomba instances managed (2..8).
- SPAWN_X, {11'd1400,11'd1100,11'd800,11'd500}, packed N_SLOTS×11-bit world X per slot; slot i at bits [11i+10:11i].
- SCREEN_W, 640, visible width in pixels.
- SPAWN_AHEAD, 32, pixels beyond the right screen edge at which a slot spawns.
- TIMEOUT, 255, max cycles to wait for a checker response (8-bit counter).

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- camera_x  in  11  world X of the screen's left edge.
- live  in  N_SLOTS  live outputs of the Goomba instances.
- show  out  N_SLOTS  initial_show to each Goomba; sticky once set.
- collapsion_tgl  out  N_SLOTS  collapsion_impulse per Goomba; toggles once per side hit.
- press_tgl  out  N_SLOTS  press_impulse per Goomba; toggles once per stomp.
- req_valid  out  1  collision check request.
- req_idx  out  3  slot under check.
- req_ready  in  1  checker accepts the request.
- resp_valid  in  1  checker result strobe, 1 cycle.
- resp_hit  in  1  Mario overlaps the slot.
- resp_stomp  in  1  the overlap is from above; valid only when resp_hit=1.
- busy  out  1  high in REQ or RESP.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rstn` is synchronous and active-low.
- Reset values: show, collapsion_tgl, press_tgl = 0; req_valid = 0; req_idx = 0; busy = 0; state = SCAN; last grant pointer = N_SLOTS-1, so slot 0 is granted first; timeout counter = 0.
- Reset asserted mid-operation: abandons any outstanding request the same edge. A late resp_valid after reset is ignored.
- Spawn, evaluated every cycle independent of the FSM:
  - sum = {1'b0,camera_x} + SCREEN_W + SPAWN_AHEAD, computed at 12 bits with no wrap.
  - If sum >= {1'b0,SPAWN_X[i]} and show[i]=0, set show[i] next edge. Multiple slots may spawn in the same cycle.
  - show never clears except on reset, so a camera moving backwards does not despawn.
- Eligibility: elig[i] = show[i] & live[i], using the registered show. A slot spawned this cycle is eligible next cycle.
- FSM states SCAN, REQ, RESP:
  - SCAN: if elig == 0, stay. Otherwise pick the first eligible slot searching from last+1 upward with wrap; latch req_idx; go to REQ next edge.
  - REQ: req_valid=1 and req_idx stable. On the edge where req_ready=1, drop req_valid, clear the timeout counter and go to RESP. resp_valid in REQ is ignored.
  - RESP, on resp_valid=1:
    - If resp_hit & resp_stomp & live[req_idx]: toggle press_tgl[req_idx].
    - If resp_hit & ~resp_stomp & live[req_idx]: toggle collapsion_tgl[req_idx].
    - If resp_hit=0, or live[req_idx]=0 (died while pending): no toggle.
    - In every case: last = req_idx; go to SCAN.
  - RESP timeout: if the counter reaches TIMEOUT with no resp_valid, last = req_idx, no toggle, go to SCAN. resp_valid on the timeout cycle takes priority over the timeout.
- Fairness: each eligible slot is granted at most once per N_SLOTS grants. A single eligible slot is re-granted back-to-back.
- Per-check latency: SCAN→REQ is 1 cycle. With req_ready and resp_valid each asserted the cycle after entry, the minimum loop is SCAN, REQ, RESP, SCAN = 3 cycles, and a toggle is visible the cycle after resp_valid.
- Toggle rule: at most one toggle per slot per response. Never both press and collapsion toggles in one cycle.
- busy = (state != SCAN).

Test Plan:
- Reset, then camera_x=0: SPAWN_X slot0=1400 → no show. Step camera_x to 728 → show[0] rises the next cycle (728+672=1400). Step to 767 → show stays at 1; 2047 → all show=1 with no 12-bit overflow. camera_x back to 0 → show stays 1.
- All live, show=4'b1111, checker tied to req_ready=1, resp_valid=1 with resp_hit=0 → req_idx sequence 0,1,2,3,0 every 3 cycles; no toggles.
- Slot 2 request answered with resp_hit=1, resp_stomp=0 → collapsion_tgl[2] flips 0→1 one cycle after resp_valid. Repeat → flips back to 0. press_tgl unchanged.
- Slot 1 answered with resp_hit=1, resp_stomp=1 while live[1]=1 → press_tgl[1] flips. Next round with live[1]=0 → slot 1 skipped; grants go 0,2,3.
- req_ready held 0 for 10 cycles → req_valid and req_idx stable throughout. Then accept and give no response for 255 cycles → return to SCAN, next slot granted, no toggle. resp_valid arriving afterwards in SCAN is ignored.
- rstn=0 for 1 cycle while in RESP with slot 3 pending → all outputs are 0 and state is SCAN the next cycle; first grant after reset is slot 0 (show must first re-arm via camera_x).

Source files
------------

// File: rtl/goomba_scheduler.sv
// Goomba enemy bank scheduler: releases each slot as the camera approaches its spawn X,
// and shares one collision checker round-robin, turning its results into toggle impulses.
module goomba_scheduler #(
  parameter int                    N_SLOTS     = 4,
  parameter logic [N_SLOTS*11-1:0] SPAWN_X     = {11'd1400, 11'd1100, 11'd800, 11'd500},
  parameter int                    SCREEN_W    = 640,
  parameter int                    SPAWN_AHEAD = 32,
  parameter int                    TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [10:0]        camera_x,
  input  logic [N_SLOTS-1:0] live,
  output logic [N_SLOTS-1:0] show,
  output logic [N_SLOTS-1:0] collapsion_tgl,
  output logic [N_SLOTS-1:0] press_tgl,
  output logic               req_valid,
  output logic [2:0]         req_idx,
  input  logic               req_ready,
  input  logic               resp_valid,
  input  logic               resp_hit,
  input  logic               resp_stomp,
  output logic               busy
);

  localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {
    SCAN,
    REQ,
    RESP
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [7:0]           tmo_q, tmo_d;
  logic [N_SLOTS-1:0]   show_q, show_d;
  logic [N_SLOTS-1:0]   col_q, col_d;
  logic [N_SLOTS-1:0]   press_q, press_d;

  logic [11:0]          reach;
  logic [N_SLOTS-1:0]   elig;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;

  // 12-bit sum so a camera near the right end of the world cannot wrap back below a spawn X.
  assign reach = {1'b0, camera_x} + 12'(SCREEN_W + SPAWN_AHEAD);
  assign elig  = show_q & live;

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    show_d = show_q;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (reach >= {1'b0, SPAWN_X[11*i +: 11]}) show_d[i] = 1'b1;
    end
  end

  // Round-robin: first eligible slot after the last granted one, wrapping at N_SLOTS.
  always_comb begin : rr_pick
    logic [IDX_W:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_SLOTS; k++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_SLOTS)) cand = cand - (IDX_W+1)'(N_SLOTS);
      if (!pick_found && elig[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    col_d   = col_q;
    press_d = press_q;
    unique case (state_q)
      SCAN: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (req_ready) begin
          tmo_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        // A response on the timeout cycle still counts.
        if (resp_valid) begin
          if (resp_hit && live[idx_q]) begin
            if (resp_stomp) press_d[idx_q] = ~press_q[idx_q];
            else            col_d[idx_q]   = ~col_q[idx_q];
          end
          last_d  = idx_q;
          state_d = SCAN;
        end else if (tmo_q == 8'(TIMEOUT)) begin
          last_d  = idx_q;
          state_d = SCAN;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= SCAN;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_SLOTS - 1);
      tmo_q   <= '0;
      show_q  <= '0;
      col_q   <= '0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      show_q  <= show_d;
      col_q   <= col_d;
      press_q <= press_d;
    end
  end

  assign show           = show_q;
  assign collapsion_tgl = col_q;
  assign press_tgl      = press_q;
  assign req_valid      = (state_q == REQ);
  assign req_idx        = 3'(idx_q);
  assign busy           = (state_q != SCAN);

endmodule

// File: tb/tb_goomba_scheduler.sv
// Directed bench for goomba_scheduler: grants are checked by a scoreboard monitor,
// spawn/toggle/reset behaviour by direct comparisons from the stimulus thread.
module tb_goomba_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic [10:0] camera_x;
  logic [3:0]  live;
  logic [3:0]  show;
  logic [3:0]  collapsion_tgl;
  logic [3:0]  press_tgl;
  logic        req_valid;
  logic [2:0]  req_idx;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_hit;
  logic        resp_stomp;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int cyc      = 0;
  int prev_cyc = 0;
  bit have_prev = 1'b0;
  bit chk_gap   = 1'b0;
  logic rv_prev = 1'b0;
  int mon_e;

  // Slot 0 is the farthest spawn (1400), slot 3 the nearest (500).
  goomba_scheduler #(
    .N_SLOTS (4),
    .SPAWN_X ({11'd500, 11'd800, 11'd1100, 11'd1400})
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .camera_x       (camera_x),
    .live           (live),
    .show           (show),
    .collapsion_tgl (collapsion_tgl),
    .press_tgl      (press_tgl),
    .req_valid      (req_valid),
    .req_idx        (req_idx),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_hit       (resp_hit),
    .resp_stomp     (resp_stomp),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  // Grant monitor: every new request must match the next expected slot.
  always @(negedge clk) begin
    if (rstn && req_valid && !rv_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL grant_unexpected got=%0d required=none", req_idx);
      end else begin
        mon_e = exp_q.pop_front();
        check("grant_idx", int'(req_idx), mon_e);
      end
      if (chk_gap && have_prev) check("grant_period", cyc - prev_cyc, 3);
      prev_cyc  = cyc;
      have_prev = 1'b1;
    end
    rv_prev = req_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    if (!req_valid) check("req_wait_timeout", 0, 1);
  endtask

  // Checker model: accept immediately, answer the cycle after.
  task automatic serve(input logic hit, input logic stomp);
    wait_req();
    req_ready = 1'b1;
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_hit   = hit;
    resp_stomp = stomp;
    tick();
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_stomp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    rstn = 1'b0; camera_x = 11'd0; live = 4'b0000;
    req_ready = 1'b0; resp_valid = 1'b0; resp_hit = 1'b0; resp_stomp = 1'b0;
    tick(); tick();
    check("rst_show", show, 0);
    check("rst_col", collapsion_tgl, 0);
    check("rst_press", press_tgl, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_idx", req_idx, 0);
    check("rst_busy", busy, 0);

    // Spawn: reach = camera_x + 672
    rstn = 1'b1;
    tick();
    check("spawn_cam0", show, 4'b1000);
    camera_x = 11'd727; tick();
    check("spawn_cam727", show, 4'b1110);
    camera_x = 11'd728;
    check("spawn_cam728_before_edge", show, 4'b1110);
    tick();
    check("spawn_cam728", show, 4'b1111);
    camera_x = 11'd767;  tick(); check("spawn_cam767", show, 4'b1111);
    camera_x = 11'd2047; tick(); check("spawn_cam2047", show, 4'b1111);
    camera_x = 11'd0;    tick(); check("spawn_backwards", show, 4'b1111);

    // Round robin, all live, no hits: 0,1,2,3,0 at a 3-cycle period
    exp_q = '{0, 1, 2, 3, 0};
    chk_gap = 1'b1; have_prev = 1'b0;
    live = 4'b1111;
    repeat (5) serve(1'b0, 1'b0);
    chk_gap = 1'b0;
    check("rr_no_col", collapsion_tgl, 0);
    check("rr_no_press", press_tgl, 0);

    // Side hit on slot 2, twice
    exp_q.push_back(1); exp_q.push_back(2);
    serve(1'b0, 1'b0);
    serve(1'b1, 1'b0);
    check("col2_first", collapsion_tgl, 4'b0100);
    check("col2_first_press", press_tgl, 0);
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    serve(1'b0, 1'b0);
    serve(1'b0, 1'b0);
    serve(1'b0, 1'b0);
    serve(1'b1, 1'b0);
    check("col2_second", collapsion_tgl, 4'b0000);
    check("col2_second_press", press_tgl, 0);

    // Stomp on slot 1, then slot 1 dies and is skipped
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
    serve(1'b0, 1'b0);
    serve(1'b0, 1'b0);
    serve(1'b1, 1'b1);
    check("press1", press_tgl, 4'b0010);
    check("press1_col", collapsion_tgl, 0);
    live = 4'b1101;
    exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(2);
    repeat (4) serve(1'b0, 1'b0);

    // Stall on req_ready, then a response that never comes
    exp_q.push_back(3);
    wait_req();
    for (int i = 0; i < 10; i++) begin
      check("stall_req_valid", req_valid, 1);
      check("stall_req_idx", req_idx, 3);
      tick();
    end
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    live = 4'b0000;
    check("timeout_resp_cycles", n, 256);
    check("timeout_press", press_tgl, 4'b0010);
    check("timeout_col", collapsion_tgl, 0);
    resp_valid = 1'b1; resp_hit = 1'b1; resp_stomp = 1'b1;
    tick();
    resp_valid = 1'b0; resp_hit = 1'b0; resp_stomp = 1'b0;
    check("late_resp_busy", busy, 0);
    check("late_resp_press", press_tgl, 4'b0010);
    check("late_resp_col", collapsion_tgl, 0);
    live = 4'b1101;
    exp_q.push_back(0);
    serve(1'b0, 1'b0);

    // Reset while slot 3 is pending in RESP
    exp_q.push_back(2); exp_q.push_back(3);
    serve(1'b0, 1'b0);
    wait_req();
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    check("pre_reset_busy", busy, 1);
    rstn = 1'b0; live = 4'b0000;
    tick();
    check("mid_rst_show", show, 0);
    check("mid_rst_col", collapsion_tgl, 0);
    check("mid_rst_press", press_tgl, 0);
    check("mid_rst_req_valid", req_valid, 0);
    check("mid_rst_req_idx", req_idx, 0);
    check("mid_rst_busy", busy, 0);
    rstn = 1'b1;
    resp_valid = 1'b1; resp_hit = 1'b1; resp_stomp = 1'b1;
    tick();
    resp_valid = 1'b0; resp_hit = 1'b0; resp_stomp = 1'b0;
    check("post_rst_press", press_tgl, 0);
    check("post_rst_col", collapsion_tgl, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_show", show, 4'b1000);
    camera_x = 11'd2047; tick();
    check("rearm_no_wrap", show, 4'b1111);
    live = 4'b1111;
    exp_q.push_back(0);
    serve(1'b0, 1'b0);
    live = 4'b0000;
    tick(); tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
